// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------
// cpu_types_pkg: shared CPU/RAM handshake types.   Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

`default_nettype wire

// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------
// ram_arb_pkg: arbiter state encoding and sizing helpers.   Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TB    = 2'd2
  } arb_state_t;

  localparam int STAT_W = 16;

  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------
// rr_priority_pick: first set request scanning from start_i with wrap.   Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module rr_priority_pick
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]              req_i,
  input  logic [grant_width(NREQ)-1:0] start_i,
  output logic                         valid_o,
  output logic [grant_width(NREQ)-1:0] idx_o
);

  localparam int GRANT_W = grant_width(NREQ);
  localparam int SUM_W   = GRANT_W + 1;

  logic [SUM_W-1:0] sum;

  // Scan offsets from the far end so the nearest requester wins last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      sum = {1'b0, start_i} + SUM_W'(o);
      if (sum >= SUM_W'(NREQ)) begin
        sum = sum - SUM_W'(NREQ);
      end
      if (req_i[sum[GRANT_W-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = sum[GRANT_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------
// ram_arbiter: round-robin NREQ-to-1 RAM arbiter with testbench override.
// Optional per-port completion counters under RAM_ARB_STATS_EN.   Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module ram_arbiter
  import ram_arb_pkg::*;
  import cpu_types_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NREQ-1:0]                   req_ren,
  input  logic [NREQ-1:0]                   req_wen,
  input  logic [NREQ-1:0][ADDR_W-1:0]       req_addr,
  input  logic [NREQ-1:0][DATA_W-1:0]       req_store,
  output logic [DATA_W-1:0]                 req_load,
  output logic [NREQ-1:0]                   req_ready,
  output logic                              req_err,
  input  logic                              tb_ctrl,
  input  logic                              tb_ren,
  input  logic                              tb_wen,
  input  logic [ADDR_W-1:0]                 tb_addr,
  input  logic [DATA_W-1:0]                 tb_store,
  output logic                              ram_ren,
  output logic                              ram_wen,
  output logic [ADDR_W-1:0]                 ram_addr,
  output logic [DATA_W-1:0]                 ram_store,
  input  logic [DATA_W-1:0]                 ram_load,
  input  ramstate_t                         ram_state,
  output logic [grant_width(NREQ)-1:0]      owner,
`ifdef RAM_ARB_STATS_EN
  output logic [NREQ-1:0][STAT_W-1:0]       grant_cnt,
`endif
  output logic                              busy
);

  localparam int GRANT_W = grant_width(NREQ);

  arb_state_t         state_q, state_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0] grant_idx_q, grant_idx_d;
  logic [GRANT_W-1:0] rr_next;
  logic [NREQ-1:0]    req_any;
  logic               pick_valid;
  logic [GRANT_W-1:0] pick_idx;

  assign req_any = req_ren | req_wen;

  rr_priority_pick #(
    .NREQ    (NREQ)
  ) u_pick (
    .req_i   (req_any),
    .start_i (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign rr_next  = (grant_idx_q == GRANT_W'(NREQ - 1)) ? '0 : grant_idx_q + GRANT_W'(1);
  assign req_load = ram_load;
  assign owner    = grant_idx_q;
  assign busy     = (state_q == GRANT) || (state_q == TB);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  // A write wins over a simultaneous read on the same port.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    ram_ren     = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_store   = '0;
    req_ready   = '0;
    req_err     = 1'b0;
    if (tb_ctrl) begin
      ram_wen   = tb_wen;
      ram_ren   = tb_ren & ~tb_wen;
      ram_addr  = tb_addr;
      ram_store = tb_store;
      state_d   = TB;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_idx_d = pick_idx;
            state_d     = GRANT;
          end
        end
        GRANT: begin
          ram_wen   = req_wen[grant_idx_q];
          ram_ren   = req_ren[grant_idx_q] & ~req_wen[grant_idx_q];
          ram_addr  = req_addr[grant_idx_q];
          ram_store = req_store[grant_idx_q];
          if (!req_any[grant_idx_q]) begin
            state_d = IDLE;
          end else if ((ram_state == ACCESS) || (ram_state == ERROR)) begin
            req_ready[grant_idx_q] = 1'b1;
            req_err                = (ram_state == ERROR);
            rr_ptr_d               = rr_next;
            state_d                = IDLE;
          end
        end
        TB: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_stats
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt_q[i] <= '0;
      end else if (req_ready[i] && (cnt_q[i] != '1)) begin
        cnt_q[i] <= cnt_q[i] + STAT_W'(1);
      end
    end
    assign grant_cnt[i] = cnt_q[i];
  end
`endif

endmodule

`default_nettype wire
